fc_feature_buffer: RTL and testbench

Double-buffered feature-vector store that sits between the last pooling/flatten stage and the fully-connected layer. Upstream writes each flattened frame as a stream of 16-bit fixed-point words. The FC layer reads words by index, and each read request gets a one-cycle-latency response. Two banks let the next frame fill while the FC layer is still reading the current one; the FC layer returns a bank with a release pulse (tied to its done flag).

---
 rtl/fc_feature_buffer.sv | 156 +++++++++++++++
 tb/tb_fc_feature_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_feature_buffer.sv
// fc_feature_buffer
//   Double-buffered feature-vector store between the flatten stage and the
//   fully-connected layer. Upstream streams one frame of DEPTH words into the
//   write bank; the FC layer reads words by index from the read bank with a
//   one-cycle response and returns the bank with a release pulse.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   wr_data/valid/last      upstream word stream, wr_last marks end of frame
//   wr_ready                buffer accepts a word this cycle
//   rd_en, rd_addr          FC read request (word index)
//   rd_data, rd_valid       response, one cycle after an accepted request
//   rd_release              FC finished with the current read bank
//   frame_avail             current read bank holds a complete frame
//   frame_short             sticky: a frame ended early and was zero-padded
//   addr_err                sticky: a served read had rd_addr >= DEPTH
module fc_feature_buffer #(
   parameter int DEPTH      = 120,
   parameter int DATA_WIDTH = 16,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   input  logic                  wr_last,
   output logic                  wr_ready,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_release,
   output logic                  frame_avail,
   output logic                  frame_short,
   output logic                  addr_err
);

   localparam logic [1:0]    W_FILL   = 2'd0;
   localparam logic [1:0]    W_PAD    = 2'd1;
   localparam logic [1:0]    W_WAIT   = 2'd2;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic [1:0]            state_q, state_d;
   logic                  wr_bank_q, wr_bank_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [AW-1:0]         wr_idx_q, wr_idx_d;
   logic [1:0]            full_q, full_d;
   logic                  short_q, short_d;
   logic                  aerr_q, aerr_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q;

   logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

   logic                  wr_fire, mem_we, close, rel, rd_fire, addr_ok;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // The state register resets to W_FILL, so ready is masked while reset is held.
   assign wr_ready    = (state_q == W_FILL) & ~reset;
   assign wr_fire     = wr_valid & wr_ready;
   assign frame_avail = full_q[rd_bank_q];
   assign rd_fire     = rd_en & frame_avail;
   assign rel         = rd_release & frame_avail;
   assign addr_ok     = {1'b0, rd_addr} < (AW + 1)'(DEPTH);

   always_comb begin
      state_d   = state_q;
      wr_bank_d = wr_bank_q;
      wr_idx_d  = wr_idx_q;
      full_d    = full_q;
      short_d   = short_q;
      mem_we    = 1'b0;
      mem_wdata = wr_data;
      close     = 1'b0;

      case (state_q)
         W_FILL: begin
            if (wr_fire) begin
               mem_we   = 1'b1;
               wr_idx_d = wr_idx_q + AW'(1);
               if (wr_idx_q == LAST_IDX) begin
                  close = 1'b1;
               end else if (wr_last) begin
                  short_d = 1'b1;
                  state_d = W_PAD;
               end
            end
         end
         W_PAD: begin
            // Zero-fill the tail of a short frame, one entry per cycle.
            mem_we    = 1'b1;
            mem_wdata = '0;
            wr_idx_d  = wr_idx_q + AW'(1);
            if (wr_idx_q == LAST_IDX) close = 1'b1;
         end
         W_WAIT: begin
            if (!full_q[wr_bank_q]) state_d = W_FILL;
         end
         default: state_d = W_FILL;
      endcase

      // Release and close never target the same bank (a bank being written
      // is never full), so both updates can be applied independently.
      if (rel) full_d[rd_bank_q] = 1'b0;
      if (close) begin
         full_d[wr_bank_q] = 1'b1;
         wr_idx_d          = '0;
         wr_bank_d         = ~wr_bank_q;
         state_d           = full_q[~wr_bank_q] ? W_WAIT : W_FILL;
      end
   end

   // Reads use the pre-release bank, so a read paired with a release is
   // served from the bank being returned.
   always_comb begin
      rd_bank_d = rel ? ~rd_bank_q : rd_bank_q;
      aerr_d    = aerr_q | (rd_fire & ~addr_ok);
      rd_data_d = rd_data_q;
      if (rd_fire) rd_data_d = addr_ok ? mem_q[rd_bank_q][rd_addr] : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= W_FILL;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_idx_q   <= '0;
         full_q     <= '0;
         short_q    <= 1'b0;
         aerr_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wr_idx_q   <= wr_idx_d;
         full_q     <= full_d;
         short_q    <= short_d;
         aerr_q     <= aerr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_fire;
      end
   end

   // Storage needs no reset: the full bits gate every read.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_bank_q][wr_idx_q] <= mem_wdata;
   end

   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign frame_short = short_q;
   assign addr_err    = aerr_q;

endmodule

// File: tb/tb_fc_feature_buffer.sv
// tb_fc_feature_buffer
//   Directed scenarios followed by a random phase. A frame-level reference
//   model (queue of closed frames, pad countdown, wait/unblock time) predicts
//   handshake and flag outputs each cycle and pushes expected read data into a
//   scoreboard queue that a negedge monitor drains against rd_valid/rd_data.
module tb_fc_feature_buffer;

   localparam int DEPTH = 120;
   localparam int DW    = 16;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] wr_data = '0;
   logic          wr_valid = 1'b0, wr_last = 1'b0, wr_ready;
   logic          rd_en = 1'b0, rd_release = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          rd_valid, frame_avail, frame_short, addr_err;

   always #5 clk = ~clk;

   fc_feature_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_release(rd_release), .frame_avail(frame_avail),
      .frame_short(frame_short), .addr_err(addr_err)
   );

   typedef struct {
      logic [DEPTH-1:0][DW-1:0] d;
      int                       av;   // first cycle the frame is readable
   } frame_t;

   frame_t                   held[$];   // closed frames, oldest first
   logic [DEPTH-1:0][DW-1:0] cur;
   int                       cnt, pad_left, block_until, cyc;
   bit                       waiting, m_short, m_aerr, rst_v;
   logic [DW-1:0]            exp_q[$];
   int                       checks, failures;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic bit m_avail();
      return held.size() > 0 && held[0].av <= cyc;
   endfunction

   function automatic bit m_ready();
      return !rst_v && pad_left == 0 && !waiting && cyc >= block_until;
   endfunction

   function automatic void close_frame();
      frame_t f;
      f.d  = cur;
      f.av = cyc + 1;
      // The other bank is still occupied: writer must wait for a release.
      if (held.size() == 1) waiting = 1'b1;
      held.push_back(f);
      cnt = 0;
      cur = '0;
   endfunction

   // One clock: drive inputs, check model-predicted outputs, advance model.
   task automatic step(input bit wv, input logic [DW-1:0] wd, input bit wl,
                       input bit re, input logic [AW-1:0] ra, input bit rr);
      bit rdy, av;
      @(negedge clk);
      #1;
      reset = rst_v; wr_valid = wv; wr_data = wd; wr_last = wl;
      rd_en = re; rd_addr = ra; rd_release = rr;
      if (rst_v) begin
         held.delete(); exp_q.delete();
         cnt = 0; cur = '0; pad_left = 0; waiting = 1'b0; block_until = 0;
         m_short = 1'b0; m_aerr = 1'b0;
      end
      #1;
      rdy = m_ready();
      av  = rst_v ? 1'b0 : m_avail();
      chk("wr_ready", 32'(wr_ready), 32'(rdy));
      chk("frame_avail", 32'(frame_avail), 32'(av));
      chk("frame_short", 32'(frame_short), 32'(m_short));
      chk("addr_err", 32'(addr_err), 32'(m_aerr));
      if (rst_v) begin
         chk("rd_valid_in_reset", 32'(rd_valid), 32'd0);
         chk("rd_data_in_reset", 32'(rd_data), 32'd0);
      end else begin
         if (re && av) begin
            exp_q.push_back(ra < AW'(DEPTH) ? held[0].d[ra] : '0);
            if (ra >= AW'(DEPTH)) m_aerr = 1'b1;
         end
         if (pad_left > 0) begin
            pad_left--;
            if (pad_left == 0) close_frame();
         end else if (wv && rdy) begin
            cur[cnt] = wd;
            if (cnt == DEPTH - 1) close_frame();
            else begin
               cnt++;
               if (wl) begin
                  m_short  = 1'b1;
                  pad_left = DEPTH - cnt;   // remaining entries, one per cycle
               end
            end
         end
         if (rr && av) begin
            void'(held.pop_front());
            if (waiting) begin
               waiting     = 1'b0;
               block_until = cyc + 2;
            end
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic rd(input int a);
      step(1'b0, '0, 1'b0, 1'b1, AW'(a), 1'b0);
   endtask

   task automatic rel();
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   // Stream n words base+i; retries a beat while the model says not ready.
   task automatic send(input logic [DW-1:0] base, input int n, input bit with_last);
      int i = 0, guard = 0;
      bit acc;
      while (i < n && guard < 2000) begin
         acc = m_ready();
         step(1'b1, DW'(base + DW'(i)), with_last && (i == n - 1), 1'b0, '0, 1'b0);
         if (acc) i++;
         guard++;
      end
      if (i < n) begin
         checks++; failures++;
         $display("FAIL send_timeout: got %0d beats expected %0d", i, n);
      end
   endtask

   // Scoreboard monitor: every rd_valid must match the oldest expectation,
   // and an expectation must be answered on the very next edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rd_valid_unexpected: got 1 expected 0 (data %0h, cyc %0d)", rd_data, cyc);
            end else begin
               chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
         end else if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL rd_valid_missing: got 0 expected 1 (cyc %0d)", cyc);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      checks = 0; failures = 0; cyc = 0;
      cnt = 0; cur = '0; pad_left = 0; block_until = 0;
      waiting = 1'b0; m_short = 1'b0; m_aerr = 1'b0;
      rst_v = 1'b1;
      idle(3);
      rst_v = 1'b0;

      // Basic fill and indexed reads.
      send(16'h0100, DEPTH, 1'b1);
      rd(0); rd(57); rd(119);
      idle(2);
      rel();
      idle(2);

      // Two frames fill both banks; a third is held off until a release.
      send(16'h1000, DEPTH, 1'b0);
      send(16'h2000, DEPTH, 1'b0);
      repeat (5) step(1'b1, 16'h3000, 1'b0, 1'b0, '0, 1'b0);
      rd(0); rd(5); rd(119);
      rel();
      rd(0); rd(5); rd(119);
      send(16'h3000, DEPTH, 1'b1);
      rel(); rel();
      idle(2);

      // Short frame, zero padded.
      send(16'h0200, 10, 1'b1);
      idle(115);
      rd(9); rd(10); rd(119);
      rel();
      idle(2);

      // Reads issued before any frame is complete are ignored.
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, DW'(16'h4000 + i), 1'b0, 1'b1, AW'(i), 1'b0);
      rd(7); rd(8);

      // Out-of-range address, then read paired with release.
      rd(120); rd(127);
      step(1'b0, '0, 1'b0, 1'b1, AW'(33), 1'b1);
      rd(33);
      idle(2);

      // Reset mid-frame while another frame is full.
      send(16'h5000, DEPTH, 1'b0);
      send(16'h5800, 60, 1'b0);
      rst_v = 1'b1;
      idle(2);
      rst_v = 1'b0;
      rd(0); rd(1); rd(2);
      send(16'h6000, DEPTH, 1'b1);
      for (int i = 0; i < DEPTH; i++) rd(i);
      rel();
      idle(2);

      // Random traffic.
      repeat (3000) begin
         logic [AW-1:0] ra;
         ra = ($urandom % 8 == 0) ? AW'(120 + $urandom % 8) : AW'($urandom % DEPTH);
         step(($urandom % 4) != 0, DW'($urandom), ($urandom % 50) == 0,
              ($urandom % 2) == 1, ra, ($urandom % 30) == 0);
      end

      idle(3);
      chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
